uart_tx_buffered: RTL and testbench
===================================

Name: uart_tx_buffered

Overview:
- Buffered UART transmitter; the outbound counterpart to the UART receive path.
- Accepts parallel words from on-chip logic over a valid/ready handshake and stores them in an internal FIFO.
- Serializes each word onto tx_o as start bit, data (LSB first), optional even parity, and stop bit(s).
- Sits between the board-level TX pin and any producer (echo path, debug console, host bridge), so producers need not wait out a full frame.

Parameters:
- clk_per_bit_p, 10416: clock cycles per UART bit (100 MHz / 9600 baud); must be >= 2.
- data_bits_p, 8: data bits per frame, 5..9.
- parity_bit_p, 0: 1 = append even-parity bit; 0 = no parity.
- stop_bits_p, 1: stop bits per frame, 1 or 2.
- fifo_els_p, 4: FIFO depth; power of 2, >= 2.

Ports:
- clk_i  in  1  system clock.
- reset_i  in  1  asynchronous active-high reset.
- tx_v_i  in  1  input word valid.
- tx_i  in  data_bits_p  input word.
- tx_ready_o  out  1  FIFO can accept a word (= not full).
- tx_o  out  1  serial line, idle high.
- busy_o  out  1  frame in progress or FIFO non-empty.
- count_o  out  $clog2(fifo_els_p+1)  words currently held in FIFO.

Behaviour:
- Interface:
  - One clock (clk_i).
  - Reset (reset_i) is asynchronous and active-high.
  - All flops reset asynchronously.
- Reset values: tx_o=1, tx_ready_o=1, busy_o=0, count_o=0, FSM=IDLE, FIFO pointers=0.
- Handshake and FIFO:
  - A word is accepted on a rising edge where tx_v_i & tx_ready_o.
  - tx_ready_o = (count_o != fifo_els_p); it depends only on registered state, not on a same-cycle pop.
  - A write while full is ignored; the producer must hold tx_v_i.
  - Simultaneous push and pop with count non-zero and not full: count unchanged.
  - Pointers wrap modulo fifo_els_p.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: tx_o=1. If FIFO non-empty, pop head into shift register; go to START with tx_o=0 on the same edge.
  - START: hold tx_o=0 for clk_per_bit_p cycles, then go to DATA with tx_o = shift[0].
  - DATA: each bit held clk_per_bit_p cycles, LSB first. After data_bits_p bits go to PARITY if parity_bit_p, otherwise go to STOP.
  - PARITY: tx_o = XOR of the data bits (even parity), held clk_per_bit_p cycles.
  - STOP: tx_o=1 for stop_bits_p*clk_per_bit_p cycles. At expiry, if FIFO non-empty, pop and go directly to START (no idle gap); otherwise go to IDLE.
- Bit timing:
  - Down-counter of width $clog2(clk_per_bit_p) (min 1).
  - Reloads to clk_per_bit_p-1 on every bit transition.
  - Every bit is exactly clk_per_bit_p cycles; tx_o is registered and glitch-free.
- Latency: word accepted at edge N into an empty FIFO with FSM in IDLE → tx_o falls at edge N+1.
- Frame length: (1 + data_bits_p + parity_bit_p + stop_bits_p) * clk_per_bit_p cycles.
- busy_o = (FSM != IDLE) | (count_o != 0).
- Reset mid-frame: tx_o goes high immediately (asynchronous), the frame is truncated, and FIFO contents are discarded.
- tx_i bits above data_bits_p: not applicable (width exact).

Optional Feature:
- Macro: UART_TX_FLOW_CTRL_EN.
- When defined:
  - Adds input port cts_n_i (1 bit, active-low clear-to-send), passed through a 2-flop synchronizer (reset value 1 = not clear).
  - The FSM leaves IDLE or STOP-expiry into START only when the synchronized cts_n is 0; otherwise it waits in IDLE with tx_o=1.
  - A frame already started always completes regardless of cts_n_i.
- When undefined: no cts_n_i port; behaves as if CTS is permanently asserted.

Test Plan:
All scenarios use clk_per_bit_p=4, data_bits_p=8, fifo_els_p=4 unless stated.
- Single frame: write 0x55, no parity, 1 stop → tx_o low 1 cycle after accept; pattern 0,1,0,1,0,1,0,1,0,1, each 4 cycles (40 cycles); busy_o drops at frame end.
- Parity: parity_bit_p=1, write 0x07 → parity bit 1. Write 0x03 → parity bit 0. Frame length 44 cycles.
- Full FIFO: hold tx_v_i with 0xA0..0xA5 while cts_n_i=1 (feature on) or during a frame → at most 4 buffered plus 1 in flight; tx_ready_o low when count_o=4; all 6 bytes later emitted in order, no loss or duplication.
- Back-to-back: queue 0x00 and 0xFF, stop_bits_p=2 → second start bit immediately follows the 8-cycle stop period, no idle gap.
- Reset mid-frame: assert reset_i during data bit 3 of 0x0F with 2 words queued → tx_o=1, count_o=0, busy_o=0 without a clock edge; after release, nothing transmitted.
- Flow control (UART_TX_FLOW_CTRL_EN): cts_n_i=1, write 0x41 → tx_o stays 1. Drop cts_n_i → start bit within 3 cycles. Raising cts_n_i mid-frame does not truncate the frame.

Source files
------------

// File: rtl/uart_tx_buffered.sv
// uart_tx_buffered
// Buffered UART transmitter. Producers hand words over a valid/ready
// handshake into a small FIFO. A frame engine serializes each word onto tx_o
// as a start bit, the data bits LSB first, an optional even-parity bit and
// one or two stop bits.
//
// Optional build macro: UART_TX_FLOW_CTRL_EN
//   Adds cts_n_i (active-low clear-to-send, 2-flop synchronized). A new frame
//   only starts while the synchronized CTS is asserted. A frame that has
//   already started always completes.
//
// Ports:
//   clk_i       system clock
//   reset_i     asynchronous active-high reset
//   cts_n_i     clear-to-send, active low (only with UART_TX_FLOW_CTRL_EN)
//   tx_v_i      input word valid
//   tx_i        input word
//   tx_ready_o  FIFO can accept a word (not full)
//   tx_o        serial line, idle high
//   busy_o      frame in progress or FIFO non-empty
//   count_o     words currently held in the FIFO
module uart_tx_buffered #(
    parameter int clk_per_bit_p = 10416,
    parameter int data_bits_p   = 8,
    parameter int parity_bit_p  = 0,
    parameter int stop_bits_p   = 1,
    parameter int fifo_els_p    = 4
) (
    input  logic                              clk_i,
    input  logic                              reset_i,
`ifdef UART_TX_FLOW_CTRL_EN
    input  logic                              cts_n_i,
`endif
    input  logic                              tx_v_i,
    input  logic [data_bits_p-1:0]            tx_i,
    output logic                              tx_ready_o,
    output logic                              tx_o,
    output logic                              busy_o,
    output logic [$clog2(fifo_els_p+1)-1:0]   count_o
);

    localparam int cnt_w_lp   = ($clog2(clk_per_bit_p) > 1) ? $clog2(clk_per_bit_p) : 1;
    localparam int ptr_w_lp   = $clog2(fifo_els_p);
    localparam int count_w_lp = $clog2(fifo_els_p + 1);
    localparam int idx_w_lp   = $clog2(data_bits_p + 1);

    localparam logic [cnt_w_lp-1:0]   reload_lp    = cnt_w_lp'(clk_per_bit_p - 1);
    localparam logic [count_w_lp-1:0] full_lp      = count_w_lp'(fifo_els_p);
    localparam logic [idx_w_lp-1:0]   last_data_lp = idx_w_lp'(data_bits_p - 1);
    localparam logic [idx_w_lp-1:0]   last_stop_lp = idx_w_lp'(stop_bits_p - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    // ------------------------------------------------------------------
    // Clear-to-send
    // ------------------------------------------------------------------
    logic cts_ok;
`ifdef UART_TX_FLOW_CTRL_EN
    logic cts_meta_reg, cts_sync_reg;
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            cts_meta_reg <= 1'b1;
            cts_sync_reg <= 1'b1;
        end else begin
            cts_meta_reg <= cts_n_i;
            cts_sync_reg <= cts_meta_reg;
        end
    end
    assign cts_ok = ~cts_sync_reg;
`else
    assign cts_ok = 1'b1;
`endif

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    logic [data_bits_p-1:0] mem [fifo_els_p];
    logic [ptr_w_lp-1:0]    wr_ptr_reg, rd_ptr_reg;
    logic [count_w_lp-1:0]  count_reg, count_next;
    logic                   full, empty, push, pop;
    logic [data_bits_p-1:0] head;

    assign full  = (count_reg == full_lp);
    assign empty = (count_reg == '0);
    assign push  = tx_v_i & ~full;
    assign head  = mem[rd_ptr_reg];

    // Storage carries no reset: contents are meaningless once the pointers clear.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr_reg] <= tx_i;
        end
    end

    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + count_w_lp'(1);
            2'b01:   count_next = count_reg - count_w_lp'(1);
            default: count_next = count_reg;
        endcase
    end

    // Depth is a power of two, so pointers wrap naturally.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + ptr_w_lp'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + ptr_w_lp'(1);
            count_reg <= count_next;
        end
    end

    // ------------------------------------------------------------------
    // Frame engine
    // ------------------------------------------------------------------
    state_t                 state_reg, state_next;
    logic [cnt_w_lp-1:0]    cnt_reg, cnt_next;
    logic [idx_w_lp-1:0]    idx_reg, idx_next;
    logic [data_bits_p-1:0] shift_reg, shift_next;
    logic                   parity_reg, parity_next;
    logic                   tx_reg, tx_next;
    logic                   bit_done, can_start;

    assign bit_done  = (cnt_reg == '0);
    assign can_start = ~empty & cts_ok;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_reg  <= IDLE;
            cnt_reg    <= reload_lp;
            idx_reg    <= '0;
            shift_reg  <= '0;
            parity_reg <= 1'b0;
            tx_reg     <= 1'b1;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            idx_reg    <= idx_next;
            shift_reg  <= shift_next;
            parity_reg <= parity_next;
            tx_reg     <= tx_next;
        end
    end

    // tx_next is the line value for the coming bit period; the bit on the
    // line is always registered, so every transition lands on a clock edge.
    // The shift register is pre-shifted: shift_reg[0] is the next data bit.
    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg - cnt_w_lp'(1);
        idx_next    = idx_reg;
        shift_next  = shift_reg;
        parity_next = parity_reg;
        tx_next     = tx_reg;
        pop         = 1'b0;
        case (state_reg)
            IDLE: begin
                tx_next  = 1'b1;
                cnt_next = reload_lp;
                if (can_start) begin
                    pop         = 1'b1;
                    state_next  = START;
                    tx_next     = 1'b0;
                    shift_next  = head;
                    parity_next = ^head;
                end
            end
            START: begin
                if (bit_done) begin
                    state_next = DATA;
                    cnt_next   = reload_lp;
                    idx_next   = '0;
                    tx_next    = shift_reg[0];
                    shift_next = shift_reg >> 1;
                end
            end
            DATA: begin
                if (bit_done) begin
                    cnt_next = reload_lp;
                    if (idx_reg == last_data_lp) begin
                        if (parity_bit_p != 0) begin
                            state_next = PARITY;
                            tx_next    = parity_reg;
                        end else begin
                            state_next = STOP;
                            tx_next    = 1'b1;
                            idx_next   = '0;
                        end
                    end else begin
                        idx_next   = idx_reg + idx_w_lp'(1);
                        tx_next    = shift_reg[0];
                        shift_next = shift_reg >> 1;
                    end
                end
            end
            PARITY: begin
                if (bit_done) begin
                    state_next = STOP;
                    cnt_next   = reload_lp;
                    tx_next    = 1'b1;
                    idx_next   = '0;
                end
            end
            STOP: begin
                if (bit_done) begin
                    cnt_next = reload_lp;
                    if (idx_reg == last_stop_lp) begin
                        // Chain straight into the next start bit when a word waits.
                        if (can_start) begin
                            pop         = 1'b1;
                            state_next  = START;
                            tx_next     = 1'b0;
                            shift_next  = head;
                            parity_next = ^head;
                        end else begin
                            state_next = IDLE;
                            tx_next    = 1'b1;
                        end
                    end else begin
                        idx_next = idx_reg + idx_w_lp'(1);
                    end
                end
            end
            default: begin
                state_next = IDLE;
                tx_next    = 1'b1;
            end
        endcase
    end

    always_comb begin
        tx_o       = tx_reg;
        tx_ready_o = ~full;
        busy_o     = (state_reg != IDLE) | ~empty;
        count_o    = count_reg;
    end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Testbench for uart_tx_buffered: 4 clocks/bit, 8 data bits, even parity,
// 2 stop bits, 4-deep FIFO. The driver records each accepted word and its
// accept edge in a scoreboard queue. The monitor derives the expected line
// waveform, FIFO count, ready and busy from that queue alone. It checks them
// every cycle and each frame bit over its full bit period.
module tb_uart_tx_buffered;

    localparam int CPB        = 4;
    localparam int DB         = 8;
    localparam int PAR        = 1;
    localparam int SB         = 2;
    localparam int DEPTH      = 4;
    localparam int FRAME_BITS = 1 + DB + PAR + SB;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tx_v = 1'b0;
    logic [7:0] tx_d = 8'h00;
    logic       tx_ready, tx_line, busy;
    logic [2:0] count;
`ifdef UART_TX_FLOW_CTRL_EN
    logic       cts_n = 1'b0;
`endif

    uart_tx_buffered #(
        .clk_per_bit_p (CPB),
        .data_bits_p   (DB),
        .parity_bit_p  (PAR),
        .stop_bits_p   (SB),
        .fifo_els_p    (DEPTH)
    ) dut (
        .clk_i      (clk),
        .reset_i    (rst),
`ifdef UART_TX_FLOW_CTRL_EN
        .cts_n_i    (cts_n),
`endif
        .tx_v_i     (tx_v),
        .tx_i       (tx_d),
        .tx_ready_o (tx_ready),
        .tx_o       (tx_line),
        .busy_o     (busy),
        .count_o    (count)
    );

    always #5 clk = ~clk;

    // Number of rising edges so far; read on falling edges only.
    int edges = 0;
    always @(posedge clk) edges <= edges + 1;

    typedef struct {
        logic [7:0] data;
        int         acc;
    } item_t;

    item_t sb_q[$];
    int    errors = 0;
    int    checks = 0;
    bit    mon_en = 1'b0;
    bit    in_frame = 1'b0;
    int    last_end = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at edge %0d: got %0h expected %0h", name, edges, act, exp);
        end
    endtask

    // Called just after a falling edge; holds valid until the word is taken.
    task automatic send(input logic [7:0] w, output int acc_o);
        int guard;
        guard = 0;
        acc_o = -1;
        tx_v = 1'b1;
        tx_d = w;
        while (tx_ready !== 1'b1 && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 3000) begin
            checks++;
            errors++;
            $display("FAIL send_timeout word=%02h: ready stayed %b", w, tx_ready);
        end else begin
            acc_o = edges + 1;
            sb_q.push_back('{w, edges + 1});
        end
        @(negedge clk);
        tx_v = 1'b0;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while ((sb_q.size() != 0 || in_frame) && guard < 6000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 6000) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d words pending, expected 0", sb_q.size());
        end
        repeat (3) @(negedge clk);
    endtask

    // Monitor: expected frame start = max(accept edge + 1, end of previous frame).
    initial begin : monitor
        item_t cur;
        logic  exp_bits [FRAME_BITS];
        int    pos, exp_start, exp_cnt;
        bit    bit_bad;
        pos = 0;
        bit_bad = 1'b0;
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                in_frame = 1'b0;
                continue;
            end
            if (!in_frame && sb_q.size() > 0) begin
                exp_start = (sb_q[0].acc + 1 > last_end) ? sb_q[0].acc + 1 : last_end;
                if (edges >= exp_start) begin
                    cur = sb_q.pop_front();
                    exp_bits[0] = 1'b0;
                    for (int i = 0; i < DB; i++) exp_bits[1 + i] = cur.data[i];
                    if (PAR != 0) exp_bits[1 + DB] = ^cur.data;
                    for (int s = 0; s < SB; s++) exp_bits[1 + DB + PAR + s] = 1'b1;
                    in_frame = 1'b1;
                    pos = 0;
                    bit_bad = 1'b0;
                end
            end
            exp_cnt = 0;
            foreach (sb_q[i]) if (sb_q[i].acc <= edges) exp_cnt++;
            check("count_o", 32'(count), 32'(exp_cnt));
            check("tx_ready_o", 32'(tx_ready), 32'(exp_cnt != DEPTH));
            check("busy_o", 32'(busy), 32'(in_frame || exp_cnt != 0));
            if (in_frame) begin
                if (tx_line !== exp_bits[pos / CPB]) bit_bad = 1'b1;
                if (pos % CPB == CPB - 1) begin
                    checks++;
                    if (bit_bad) begin
                        errors++;
                        $display("FAIL frame_bit word=%02h bit=%0d edge=%0d: line %b expected %b held %0d cycles",
                                 cur.data, pos / CPB, edges, tx_line, exp_bits[pos / CPB], CPB);
                    end
                    bit_bad = 1'b0;
                end
                pos++;
                if (pos == FRAME_BITS * CPB) begin
                    in_frame = 1'b0;
                    last_end = edges + 1;
                    $display("frame word=%02h ended at edge %0d", cur.data, edges);
                end
            end else begin
                check("idle_line", 32'(tx_line), 32'd1);
            end
        end
    end

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int acc, acc0, gap, guard;
        logic [7:0] w;

        #1 rst = 1'b1;
        #2;
        check("reset_tx_o", 32'(tx_line), 32'd1);
        check("reset_ready", 32'(tx_ready), 32'd1);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_count", 32'(count), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        mon_en = 1'b1;
        repeat (4) @(negedge clk);

        // Single frame and parity polarity cases.
        send(8'h55, acc); drain();
        send(8'h07, acc); drain();
        send(8'h03, acc); drain();

        // Fill the FIFO behind a frame in flight.
        for (int i = 0; i < 6; i++) send(8'hA0 + 8'(i), acc);
        drain();

        // Back-to-back frames across the two-bit stop period.
        send(8'h00, acc);
        send(8'hFF, acc);
        drain();

        // Randomized traffic with random gaps.
        for (int i = 0; i < 40; i++) begin
            w = 8'($urandom_range(0, 255));
            send(w, acc);
            gap = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 60) : $urandom_range(0, 3);
            repeat (gap) @(negedge clk);
        end
        drain();

        // Reset during data bit 3 of 0x0F with two words queued behind it.
        send(8'h0F, acc0);
        send(8'h11, acc);
        send(8'h22, acc);
        guard = 0;
        while (edges < acc0 + 1 + 4 * CPB + 1 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("pre_reset_count", 32'(count), 32'd2);
        mon_en = 1'b0;
        #1 rst = 1'b1;
        #1;
        check("async_reset_tx_o", 32'(tx_line), 32'd1);
        check("async_reset_count", 32'(count), 32'd0);
        check("async_reset_busy", 32'(busy), 32'd0);
        check("async_reset_ready", 32'(tx_ready), 32'd1);
        sb_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        last_end = 0;
        mon_en = 1'b1;
        repeat (80) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
